// File: rtl/tile_pkg.sv
// Shared types and constants for the tile pixel store and its loader.
// 256x256 pixels = 32x32 tiles of 8x8, 4 bpp, 16-bit words of 4 pixels.
package tile_pkg;

  localparam int TILE_GRID_BITS = 5;
  localparam int TILE_ROW_BITS  = 3;
  localparam int TILE_WORD_W    = 16;
  localparam int TILE_IDX_W     = 2 * TILE_GRID_BITS;
  localparam int TILE_WCNT_W    = TILE_ROW_BITS + 1;
  localparam int TILE_CNT_W     = TILE_IDX_W + 1;

  // Word address in the same layout as the draw-side read port.
  typedef struct packed {
    logic [TILE_GRID_BITS-1:0] y;
    logic [TILE_ROW_BITS-1:0]  row;
    logic [TILE_GRID_BITS-1:0] x;
    logic                      col;
  } tile_addr_t;

  // Tile index {tile_y, tile_x}.
  typedef logic [TILE_IDX_W-1:0] tile_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } tile_loader_state_e;

endpackage

// File: rtl/tile_loader_if.sv
// Pixel word stream in, tile memory write port out.
// slave: the loader; master: the host side that feeds words and watches writes.
interface tile_loader_if;
  import tile_pkg::*;

  logic [TILE_WORD_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   wr_en;
  tile_addr_t             wr_addr;
  logic [TILE_WORD_W-1:0] wr_data;

  modport slave  (input in_data, in_valid, output in_ready, wr_en, wr_addr, wr_data);
  modport master (output in_data, in_valid, input in_ready, wr_en, wr_addr, wr_data);

endinterface

// File: rtl/tile_loader_cursor.sv
// Write cursor: tile index plus 4-bit word counter {row, col}.
// Word order within a tile is r0c0, r0c1, r1c0 ... r7c1; after the last
// word the tile index steps x first, carrying into y, wrapping 1023 -> 0.
module tile_cursor
  import tile_pkg::*;
(
  input  logic       clk_draw,
  input  logic       rst_draw_n,
  input  logic       load,
  input  tile_idx_t  load_idx,
  input  logic       advance,
  output tile_addr_t addr,
  output logic       last_word_of_tile
);

  tile_idx_t              idx_q;
  logic [TILE_WCNT_W-1:0] word_q;

  // Cursor register: load restarts at word 0 of load_idx, advance steps one word.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (load) begin
      idx_q  <= load_idx;
      word_q <= '0;
    end else if (advance) begin
      word_q <= word_q + 1'b1;
      if (last_word_of_tile) idx_q <= idx_q + 1'b1;
    end
  end

  assign last_word_of_tile = &word_q;

  assign addr = '{
    y:   idx_q[TILE_IDX_W-1:TILE_GRID_BITS],
    row: word_q[TILE_WCNT_W-1:1],
    x:   idx_q[TILE_GRID_BITS-1:0],
    col: word_q[0]
  };

endmodule

// File: rtl/tile_loader.sv
// tile_loader: write-side sequencer for the tile pixel store. Takes a run of
// tiles as a valid/ready word stream and issues one registered write per word.
// Optional: TILE_LOADER_CHECKSUM_EN adds a running 16-bit sum of accepted words.
module tile_loader
  import tile_pkg::*;
(
  input  logic                  clk_draw,
  input  logic                  rst_draw_n,
  input  logic                  start,
  input  tile_idx_t             start_tile,
  input  logic [TILE_CNT_W-1:0] tile_count,
  input  logic                  abort,
  tile_loader_if.slave          bus,
  output logic                  busy,
  output logic                  done
`ifdef TILE_LOADER_CHECKSUM_EN
  ,
  output logic [TILE_WORD_W-1:0] checksum
`endif
);

  tile_loader_state_e    state_q, state_d;
  logic [TILE_CNT_W-1:0] rem_q;
  logic                  in_ready;
  logic                  hs;
  logic                  start_acc;
  logic                  cur_load;
  logic                  last_word;
  tile_addr_t            cur_addr;

  logic                   wr_en_q;
  tile_addr_t             wr_addr_q;
  logic [TILE_WORD_W-1:0] wr_data_q;

  tile_cursor u_cursor (
    .clk_draw          (clk_draw),
    .rst_draw_n        (rst_draw_n),
    .load              (cur_load),
    .load_idx          (start_tile),
    .advance           (hs),
    .addr              (cur_addr),
    .last_word_of_tile (last_word)
  );

  assign start_acc = (state_q == ST_IDLE) && start;
  assign hs        = bus.in_valid && in_ready;

  // State register.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next state and stream ready; abort masks ready so it beats a same-cycle handshake.
  always_comb begin
    state_d  = state_q;
    cur_load = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (tile_count != '0) begin
            state_d  = ST_LOAD;
            cur_load = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        in_ready = !abort;
        if (abort)
          state_d = ST_IDLE;
        else if (bus.in_valid && last_word && rem_q == TILE_CNT_W'(1))
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Tiles still to load, counting the one in progress.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n)            rem_q <= '0;
    else if (cur_load)          rem_q <= tile_count;
    else if (hs && last_word)   rem_q <= rem_q - 1'b1;
  end

  // Registered write port: one-cycle strobe per accepted word.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= hs;
      if (hs) begin
        wr_addr_q <= cur_addr;
        wr_data_q <= bus.in_data;
      end
    end
  end

`ifdef TILE_LOADER_CHECKSUM_EN
  logic [TILE_WORD_W-1:0] sum_q;

  // Running sum of accepted words; lines up with the matching wr_en.
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n)    sum_q <= '0;
    else if (start_acc) sum_q <= '0;
    else if (hs)        sum_q <= sum_q + bus.in_data;
  end

  assign checksum = sum_q;
`endif

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_tile_loader.sv
// Directed bench for tile_loader; checksum scenarios run only when
// TILE_LOADER_CHECKSUM_EN is defined.
module tb_tile_loader;
  import tile_pkg::*;

  logic        clk_draw = 1'b0;
  logic        rst_draw_n = 1'b0;
  logic        start = 1'b0;
  tile_idx_t   start_tile = '0;
  logic [10:0] tile_count = '0;
  logic        abort = 1'b0;
  logic        busy, done;
`ifdef TILE_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  tile_loader_if bus();

  tile_loader dut (
    .clk_draw   (clk_draw),
    .rst_draw_n (rst_draw_n),
    .start      (start),
    .start_tile (start_tile),
    .tile_count (tile_count),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
`ifdef TILE_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk_draw = ~clk_draw;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [13:0] mon_addr[$];
  logic [15:0] mon_data[$];

  logic [13:0] single_addr [16] = '{
    14'h0000, 14'h0001, 14'h0040, 14'h0041, 14'h0080, 14'h0081, 14'h00C0, 14'h00C1,
    14'h0100, 14'h0101, 14'h0140, 14'h0141, 14'h0180, 14'h0181, 14'h01C0, 14'h01C1};

  // Capture writes and done pulses mid-cycle.
  always @(negedge clk_draw) begin
    if (rst_draw_n) begin
      if (bus.wr_en) begin
        mon_addr.push_back(bus.wr_addr);
        mon_data.push_back(bus.wr_data);
      end
      if (done) done_cnt++;
    end
  end

  // Address of word w in tile index t: {y, row, x, col}.
  function automatic logic [13:0] exp_addr(input int tile, input int w);
    int t;
    t = tile % 1024;
    exp_addr = 14'(((t / 32) * 512) + ((w / 2) * 64) + ((t % 32) * 2) + (w % 2));
  endfunction

  task automatic tick();
    @(posedge clk_draw);
    #1;
  endtask

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    done_cnt = 0;
  endtask

  task automatic start_load(input tile_idx_t t, input logic [10:0] n);
    start = 1'b1; start_tile = t; tile_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(base + 16'(i));
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (bus.wr_addr !== 14'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", bus.wr_addr); end
    n_checks++; if (bus.wr_data !== 16'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
`ifdef TILE_LOADER_CHECKSUM_EN
    n_checks++; if (checksum !== 16'h0) begin n_fail++; $display("FAIL reset_checksum: got %h want 0", checksum); end
`endif
  endtask

  task automatic test_single_tile();
    clear_mon();
    start_load(10'd0, 11'd1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %b want 1", busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_data = 16'h0000;
    tick();
    n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 14'h0000) begin n_fail++; $display("FAIL single_first_write: got en=%b addr=%h want en=1 addr=0000", bus.wr_en, bus.wr_addr); end
    feed(16'h0001, 14);
    bus.in_valid = 1'b1; bus.in_data = 16'h000F;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (done !== 1'b1 || bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL single_done_with_last: got done=%b en=%b want 1 1", done, bus.wr_en); end
    n_checks++; if (bus.wr_addr !== 14'h01C1 || bus.wr_data !== 16'h000F) begin n_fail++; $display("FAIL single_last_write: got %h/%h want 01c1/000f", bus.wr_addr, bus.wr_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_in_done: got %b want 1", busy); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: got done=%b busy=%b en=%b want 0 0 0", done, busy, bus.wr_en); end
    n_checks++; if (mon_addr.size() != 16) begin n_fail++; $display("FAIL single_write_count: got %0d want 16", mon_addr.size()); end
    for (int i = 0; i < 16 && i < mon_addr.size(); i++) begin
      n_checks++;
      if (mon_addr[i] !== single_addr[i] || mon_data[i] !== 16'(i)) begin
        n_fail++; $display("FAIL single_word%0d: got %h/%h want %h/%h", i, mon_addr[i], mon_data[i], single_addr[i], 16'(i));
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
  endtask

`ifdef TILE_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_mon();
    start_load(10'd0, 11'd1);
    n_checks++; if (checksum !== 16'h0) begin n_fail++; $display("FAIL cks_cleared: got %h want 0", checksum); end
    bus.in_valid = 1'b1; bus.in_data = 16'h1111;
    tick();
    n_checks++; if (checksum !== 16'h1111) begin n_fail++; $display("FAIL cks_first: got %h want 1111", checksum); end
    for (int i = 1; i < 16; i++) tick();
    bus.in_valid = 1'b0;
    n_checks++; if (checksum !== 16'h1110 || bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL cks_final: got %h en=%b want 1110 en=1", checksum, bus.wr_en); end
    tick(); tick();
    n_checks++; if (checksum !== 16'h1110) begin n_fail++; $display("FAIL cks_hold: got %h want 1110", checksum); end
  endtask
`endif

  task automatic test_tile_wrap();
    clear_mon();
    start_load(10'h3FF, 11'd2);
    feed(16'h0100, 32);
    tick(); tick();
    n_checks++; if (mon_addr.size() != 32) begin n_fail++; $display("FAIL wrap_write_count: got %0d want 32", mon_addr.size()); end
    if (mon_addr.size() == 32) begin
      n_checks++; if (mon_addr[0] !== 14'h3E3E) begin n_fail++; $display("FAIL wrap_first_addr: got %h want 3e3e", mon_addr[0]); end
      n_checks++; if (mon_addr[16] !== 14'h0000) begin n_fail++; $display("FAIL wrap_second_tile: got %h want 0000", mon_addr[16]); end
      n_checks++; if (mon_addr[15] !== 14'h3FFF) begin n_fail++; $display("FAIL wrap_tile_end: got %h want 3fff", mon_addr[15]); end
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (mon_addr[i] !== exp_addr(1023 + i / 16, i % 16) || mon_data[i] !== 16'(16'h0100 + i)) begin
          n_fail++; $display("FAIL wrap_word%0d: got %h/%h want %h/%h", i, mon_addr[i], mon_data[i], exp_addr(1023 + i / 16, i % 16), 16'(16'h0100 + i));
        end
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    start_load(10'd33, 11'd1);
    for (int c = 0; c < 32; c++) begin
      bus.in_valid = (c % 2 == 0);
      bus.in_data  = 16'(16'h2000 + c);
      tick();
    end
    // valid while idle must not be consumed
    bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
    tick(); tick();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_idle_ready: got %b want 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (mon_addr.size() != 16) begin n_fail++; $display("FAIL bp_write_count: got %0d want 16", mon_addr.size()); end
    for (int k = 0; k < 16 && k < mon_addr.size(); k++) begin
      n_checks++;
      if (mon_addr[k] !== exp_addr(33, k) || mon_data[k] !== 16'(16'h2000 + 2 * k)) begin
        n_fail++; $display("FAIL bp_word%0d: got %h/%h want %h/%h", k, mon_addr[k], mon_data[k], exp_addr(33, k), 16'(16'h2000 + 2 * k));
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    clear_mon();
    start_load(10'd5, 11'd1);
    feed(16'h3000, 5);
    bus.in_valid = 1'b1; bus.in_data = 16'h3005; abort = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== exp_addr(5, 4)) begin n_fail++; $display("FAIL abort_prev_write: got en=%b addr=%h want 1 %h", bus.wr_en, bus.wr_addr, exp_addr(5, 4)); end
    tick();
    abort = 1'b0; bus.in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0 || bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b en=%b want 0 0", busy, bus.wr_en); end
    tick(); tick();
    n_checks++; if (mon_addr.size() != 5) begin n_fail++; $display("FAIL abort_write_count: got %0d want 5", mon_addr.size()); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
    clear_mon();
    start_load(10'd6, 11'd1);
    feed(16'h4000, 16);
    tick(); tick();
    n_checks++; if (mon_addr.size() != 16) begin n_fail++; $display("FAIL restart_write_count: got %0d want 16", mon_addr.size()); end
    if (mon_addr.size() == 16) begin
      n_checks++; if (mon_addr[0] !== 14'h000C || mon_addr[15] !== 14'h01CD) begin n_fail++; $display("FAIL restart_addrs: got %h..%h want 000c..01cd", mon_addr[0], mon_addr[15]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_edge_starts();
    clear_mon();
    start_load(10'd7, 11'd0);
    n_checks++; if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL zero_done: got done=%b busy=%b want 1 1", done, busy); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got done=%b busy=%b want 0 0", done, busy); end
    n_checks++; if (mon_addr.size() != 0) begin n_fail++; $display("FAIL zero_writes: got %0d want 0", mon_addr.size()); end
    clear_mon();
    start_load(10'd2, 11'd1);
    feed(16'h5000, 3);
    start = 1'b1; start_tile = 10'd9; tile_count = 11'd3;
    bus.in_valid = 1'b1; bus.in_data = 16'h5003;
    tick();
    start = 1'b0;
    feed(16'h5004, 12);
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_ignored_busy: got %b want 0", busy); end
    n_checks++; if (mon_addr.size() != 16) begin n_fail++; $display("FAIL restart_ignored_count: got %0d want 16", mon_addr.size()); end
    for (int i = 0; i < 16 && i < mon_addr.size(); i++) begin
      n_checks++;
      if (mon_addr[i] !== exp_addr(2, i) || mon_data[i] !== 16'(16'h5000 + i)) begin
        n_fail++; $display("FAIL restart_ignored_word%0d: got %h/%h want %h/%h", i, mon_addr[i], mon_data[i], exp_addr(2, i), 16'(16'h5000 + i));
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL restart_ignored_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_midload();
    clear_mon();
    start_load(10'd0, 11'd1);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'(16'h6001 + i);
      tick();
    end
    rst_draw_n = 1'b0;
    #1;
    n_checks++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 14'h0 || bus.wr_data !== 16'h0) begin n_fail++; $display("FAIL rst_mid_write: got en=%b %h/%h want 0 0/0", bus.wr_en, bus.wr_addr, bus.wr_data); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got busy=%b done=%b rdy=%b want 0 0 0", busy, done, bus.in_ready); end
`ifdef TILE_LOADER_CHECKSUM_EN
    n_checks++; if (checksum !== 16'h0) begin n_fail++; $display("FAIL rst_mid_checksum: got %h want 0", checksum); end
`endif
    tick();
    rst_draw_n = 1'b1;
    tick();
    n_checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0 || bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got rdy=%b busy=%b en=%b want 0 0 0", bus.in_ready, busy, bus.wr_en); end
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (mon_addr.size() != 3) begin n_fail++; $display("FAIL rst_mid_writes: got %0d want 3", mon_addr.size()); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_draw_n   = 1'b0;
    test_reset();
    @(posedge clk_draw);
    #1 rst_draw_n = 1'b1;
    tick();
    test_single_tile();
`ifdef TILE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_tile_wrap();
    test_backpressure();
    test_abort();
    test_edge_starts();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
